// File: rtl/vga_mem_arbiter.sv
// Single-port video memory arbiter: scanout has priority, and a starvation counter
// guarantees host progress. Read data is routed back one cycle after the grant.
module vga_mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_gnt_o,
  output logic                  host_rvalid_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  input  logic                  scan_req_i,
  input  logic [ADDR_WIDTH-1:0] scan_addr_i,
  output logic                  scan_gnt_o,
  output logic                  scan_rvalid_o,
  output logic [DATA_WIDTH-1:0] scan_rdata_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  typedef enum logic {SCAN_PRIO = 1'b0, HOST_PRIO = 1'b1} state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  state_t                state;
  logic [7:0]            wait_cnt, wait_nxt;
  logic                  rd_vld, rd_host;
  logic [DATA_WIDTH-1:0] host_rdata_q, scan_rdata_q;

  // Grants are combinational; reset forces both low.
  always_comb begin
    host_gnt_o = 1'b0;
    scan_gnt_o = 1'b0;
    if (arst_n_i) begin
      if (state == HOST_PRIO) begin
        host_gnt_o = host_req_i;
        scan_gnt_o = scan_req_i & ~host_req_i;
      end else begin
        scan_gnt_o = scan_req_i;
        host_gnt_o = host_req_i & ~scan_req_i;
      end
    end
  end

  always_comb begin
    wait_nxt = wait_cnt;
    if (host_gnt_o)
      wait_nxt = 8'd0;
    else if (host_req_i && wait_cnt < WAIT_MAX)
      wait_nxt = wait_cnt + 8'd1;
  end

  // Switch on the same edge the count saturates, so the host wins the very next cycle.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state        <= SCAN_PRIO;
      wait_cnt     <= 8'd0;
      rd_vld       <= 1'b0;
      rd_host      <= 1'b0;
      host_rdata_q <= '0;
      scan_rdata_q <= '0;
    end else begin
      wait_cnt <= wait_nxt;
      case (state)
        SCAN_PRIO: if (host_req_i && !host_gnt_o && wait_nxt == WAIT_MAX) state <= HOST_PRIO;
        HOST_PRIO: if (host_gnt_o || !host_req_i) state <= SCAN_PRIO;
        default:   state <= SCAN_PRIO;
      endcase
      rd_vld  <= mem_en_o & ~mem_we_o;
      rd_host <= host_gnt_o;
      if (host_rvalid_o) host_rdata_q <= mem_rdata_i;
      if (scan_rvalid_o) scan_rdata_q <= mem_rdata_i;
    end
  end

  // Return path: pass memory data through on the response cycle, hold it afterwards.
  assign host_rvalid_o = rd_vld & rd_host;
  assign scan_rvalid_o = rd_vld & ~rd_host;
  assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : host_rdata_q;
  assign scan_rdata_o  = scan_rvalid_o ? mem_rdata_i : scan_rdata_q;

  assign mem_en_o    = host_gnt_o | scan_gnt_o;
  assign mem_we_o    = host_gnt_o & host_we_i;
  assign mem_addr_o  = scan_gnt_o ? scan_addr_i : host_addr_i;
  assign mem_wdata_o = host_wdata_i;

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    !(host_gnt_o && scan_gnt_o));
  a_host_addr_stable: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    (host_req_i && !host_gnt_o) |=> $stable(host_addr_i));
  a_scan_addr_stable: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    (scan_req_i && !scan_gnt_o) |=> $stable(scan_addr_i));
  a_rvalid_cause: assert property (@(posedge clk_i) disable iff (!arst_n_i)
    (host_rvalid_o || scan_rvalid_o) |-> $past(mem_en_o && !mem_we_o));

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter with a small single-port memory model.
module tb_vga_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic          clk_i = 1'b0;
  logic          arst_n_i;
  logic          host_req_i, host_we_i;
  logic [AW-1:0] host_addr_i;
  logic [DW-1:0] host_wdata_i;
  logic          host_gnt_o, host_rvalid_o;
  logic [DW-1:0] host_rdata_o;
  logic          scan_req_i;
  logic [AW-1:0] scan_addr_i;
  logic          scan_gnt_o, scan_rvalid_o;
  logic [DW-1:0] scan_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;

  logic          preload;
  logic [DW-1:0] mem [0:255];

  int checks = 0;
  int errors = 0;

  vga_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(8)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o),
    .host_rvalid_o(host_rvalid_o), .host_rdata_o(host_rdata_o),
    .scan_req_i(scan_req_i), .scan_addr_i(scan_addr_i), .scan_gnt_o(scan_gnt_o),
    .scan_rvalid_o(scan_rvalid_o), .scan_rdata_o(scan_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  // Words 0..7 hold C0DE_000n, every other word 1234_00nn.
  always @(posedge clk_i) begin
    if (preload) begin
      for (int j = 0; j < 256; j++)
        mem[j] <= (j < 8) ? (32'hC0DE_0000 + 32'(j)) : (32'h1234_0000 + 32'(j));
    end else if (mem_en_o) begin
      if (mem_we_o) mem[mem_addr_o[7:0]] <= mem_wdata_o;
      else          mem_rdata_i <= mem[mem_addr_o[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    preload = 1'b1; arst_n_i = 1'b0;
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = '0; host_wdata_i = '0;
    scan_req_i = 1'b1; scan_addr_i = '0;
    step();
    preload = 1'b0;
    #4;
    chk("rst_host_gnt", 64'(host_gnt_o), 64'd0);
    chk("rst_scan_gnt", 64'(scan_gnt_o), 64'd0);
    chk("rst_mem_en", 64'(mem_en_o), 64'd0);
    chk("rst_host_rvalid", 64'(host_rvalid_o), 64'd0);
    chk("rst_scan_rvalid", 64'(scan_rvalid_o), 64'd0);
    chk("rst_host_rdata", 64'(host_rdata_o), 64'd0);
    chk("rst_scan_rdata", 64'(scan_rdata_o), 64'd0);
    host_req_i = 1'b0; scan_req_i = 1'b0;
    arst_n_i = 1'b1;

    // Host write then read of 0x0010
    step();
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 16'h0010; host_wdata_i = 32'hDEADBEEF;
    #4;
    chk("wr_host_gnt", 64'(host_gnt_o), 64'd1);
    chk("wr_scan_gnt", 64'(scan_gnt_o), 64'd0);
    chk("wr_mem_we", 64'(mem_we_o), 64'd1);
    chk("wr_mem_addr", 64'(mem_addr_o), 64'h10);
    chk("wr_mem_wdata", 64'(mem_wdata_o), 64'hDEADBEEF);
    step();
    host_we_i = 1'b0;
    #4;
    chk("rd_host_gnt", 64'(host_gnt_o), 64'd1);
    chk("rd_mem_we", 64'(mem_we_o), 64'd0);
    chk("wr_no_rvalid", 64'(host_rvalid_o), 64'd0);
    chk("host_only_cnt", 64'(dut.wait_cnt), 64'd0);
    step();
    host_req_i = 1'b0;
    #4;
    chk("rd_host_rvalid", 64'(host_rvalid_o), 64'd1);
    chk("rd_host_rdata", 64'(host_rdata_o), 64'hDEADBEEF);
    chk("rd_scan_rvalid", 64'(scan_rvalid_o), 64'd0);
    chk("idle_mem_en", 64'(mem_en_o), 64'd0);
    step();
    #4;
    chk("rd_rvalid_pulse", 64'(host_rvalid_o), 64'd0);
    chk("rd_rdata_hold", 64'(host_rdata_o), 64'hDEADBEEF);

    // Scan burst 0..7
    for (int i = 0; i <= 8; i++) begin
      step();
      scan_req_i = (i < 8);
      scan_addr_i = 16'(i);
      #4;
      chk("burst_gnt", 64'(scan_gnt_o), (i < 8) ? 64'd1 : 64'd0);
      if (i > 0) begin
        chk("burst_rvalid", 64'(scan_rvalid_o), 64'd1);
        chk("burst_rdata", 64'(scan_rdata_o), 64'(32'hC0DE_0000 + 32'(i - 1)));
        chk("burst_host_rvalid", 64'(host_rvalid_o), 64'd0);
      end
    end
    step();
    #4;
    chk("burst_end_rvalid", 64'(scan_rvalid_o), 64'd0);

    // Starvation: host denied 8 cycles, granted on the 9th
    step();
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 16'h0040;
    scan_req_i = 1'b1; scan_addr_i = 16'h0050;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) step();
      #4;
      chk("starve_host_gnt", 64'(host_gnt_o), (c <= 8) ? 64'd0 : 64'd1);
      chk("starve_scan_gnt", 64'(scan_gnt_o), (c <= 8) ? 64'd1 : 64'd0);
    end
    step();
    host_req_i = 1'b0;
    #4;
    chk("starve_scan_resume", 64'(scan_gnt_o), 64'd1);
    chk("starve_host_rvalid", 64'(host_rvalid_o), 64'd1);
    chk("starve_host_rdata", 64'(host_rdata_o), 64'h1234_0040);
    chk("starve_scan_rvalid", 64'(scan_rvalid_o), 64'd0);

    // Simultaneous request with counter at 0
    step();
    host_req_i = 1'b1; host_addr_i = 16'h0021;
    scan_req_i = 1'b1; scan_addr_i = 16'h0031;
    #4;
    chk("both_scan_gnt", 64'(scan_gnt_o), 64'd1);
    chk("both_host_gnt", 64'(host_gnt_o), 64'd0);
    step();
    scan_req_i = 1'b0;
    #4;
    chk("both_host_late_gnt", 64'(host_gnt_o), 64'd1);
    chk("both_cnt_one", 64'(dut.wait_cnt), 64'd1);
    chk("both_scan_rvalid", 64'(scan_rvalid_o), 64'd1);
    chk("both_scan_rdata", 64'(scan_rdata_o), 64'h1234_0031);
    step();
    host_req_i = 1'b0;
    #4;
    chk("both_cnt_zero", 64'(dut.wait_cnt), 64'd0);
    chk("both_host_rvalid", 64'(host_rvalid_o), 64'd1);
    chk("both_host_rdata", 64'(host_rdata_o), 64'h1234_0021);

    // Interleaved host 0x20 / scan 0x30
    step();
    host_req_i = 1'b1; host_addr_i = 16'h0020;
    #4;
    chk("il_host_gnt", 64'(host_gnt_o), 64'd1);
    step();
    host_req_i = 1'b0;
    scan_req_i = 1'b1; scan_addr_i = 16'h0030;
    #4;
    chk("il_scan_gnt", 64'(scan_gnt_o), 64'd1);
    chk("il_host_rvalid", 64'(host_rvalid_o), 64'd1);
    chk("il_host_rdata", 64'(host_rdata_o), 64'h1234_0020);
    chk("il_scan_rvalid_0", 64'(scan_rvalid_o), 64'd0);
    step();
    scan_req_i = 1'b0;
    #4;
    chk("il_scan_rvalid", 64'(scan_rvalid_o), 64'd1);
    chk("il_scan_rdata", 64'(scan_rdata_o), 64'h1234_0030);
    chk("il_host_rvalid_0", 64'(host_rvalid_o), 64'd0);
    chk("il_host_rdata_hold", 64'(host_rdata_o), 64'h1234_0020);

    // Reset while a host read is in flight
    step();
    host_req_i = 1'b1; host_addr_i = 16'h0010;
    #4;
    chk("mr_host_gnt", 64'(host_gnt_o), 64'd1);
    step();
    arst_n_i = 1'b0;
    scan_req_i = 1'b1; scan_addr_i = 16'h0050;
    #4;
    chk("mr_host_gnt_0", 64'(host_gnt_o), 64'd0);
    chk("mr_scan_gnt_0", 64'(scan_gnt_o), 64'd0);
    chk("mr_mem_en_0", 64'(mem_en_o), 64'd0);
    chk("mr_host_rvalid_0", 64'(host_rvalid_o), 64'd0);
    chk("mr_scan_rvalid_0", 64'(scan_rvalid_o), 64'd0);
    chk("mr_host_rdata_0", 64'(host_rdata_o), 64'd0);
    chk("mr_scan_rdata_0", 64'(scan_rdata_o), 64'd0);
    #1;
    arst_n_i = 1'b1;
    step();
    #4;
    chk("mr_post_host_rvalid", 64'(host_rvalid_o), 64'd0);
    chk("mr_post_host_rdata", 64'(host_rdata_o), 64'd0);
    chk("mr_post_scan_gnt", 64'(scan_gnt_o), 64'd1);
    chk("mr_post_host_gnt", 64'(host_gnt_o), 64'd0);
    chk("mr_post_state", 64'(logic'(dut.state)), 64'd0);
    step();
    host_req_i = 1'b0; scan_req_i = 1'b0;
    #4;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
